// File: rtl/spi_transaction_ctrl.sv
// SPI slave (mode 0, MSB first) transaction sequencer: command frame -> memory read/write.
// Consumes conditioned CS/SCLK/MOSI levels and SCLK edge pulses; drives memory and MISO.
module spi_transaction_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_cond,
    input  logic                  sclk_pos,
    input  logic                  sclk_neg,
    input  logic                  mosi_cond,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  miso,
    output logic                  miso_en,
    output logic                  busy
);

    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int RXW      = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int CW       = $clog2(RXW) + 1;
    localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    // Handshake: sclk_pos/sclk_neg are single-cycle strobes that are acted on only
    // in the states that consume them; cs_cond high outside IDLE always wins.
    typedef enum logic [2:0] {
        IDLE, GET_CMD, LOAD, READ, WRITE, COMMIT, DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         cnt;
    logic [RXW-1:0]        rx;
    logic [DATA_WIDTH-1:0] tx;
    logic [RXW-1:0]        rx_shifted;
    logic                  abort;

    assign rx_shifted = {rx[RXW-2:0], mosi_cond};
    assign abort      = (state != IDLE) && cs_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        miso_en    = 1'b0;
        busy       = (state != IDLE);
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (!cs_cond) state_next = GET_CMD;
                // The final command bit is the R/W flag and picks the data phase.
                GET_CMD: if (sclk_pos && cnt == CMD_LAST) state_next = mosi_cond ? LOAD : WRITE;
                LOAD:    state_next = READ;
                READ:    if (sclk_pos && cnt == DATA_LAST) state_next = DONE;
                WRITE:   if (sclk_pos && cnt == DATA_LAST) state_next = COMMIT;
                COMMIT:  state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
        mem_we  = (state == COMMIT);
        miso_en = (state == READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            mem_addr <= '0;
            miso     <= 1'b0;
        end else if (abort || state == IDLE) begin
            cnt <= '0;
        end else begin
            case (state)
                GET_CMD: begin
                    if (sclk_pos) begin
                        rx <= rx_shifted;
                        if (cnt == CMD_LAST) begin
                            // Pre-shift rx holds exactly the address bits; the incoming bit is R/W.
                            mem_addr <= rx[ADDR_WIDTH-1:0];
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD: tx <= mem_rdata;
                READ: begin
                    if (sclk_neg) begin
                        miso <= tx[DATA_WIDTH-1];
                        tx   <= {tx[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sclk_pos) cnt <= cnt + CW'(1);
                end
                WRITE: begin
                    if (sclk_pos) begin
                        rx  <= rx_shifted;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = rx[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// Directed + randomized bench for spi_transaction_ctrl against a byte-level memory model.
module tb_spi_transaction_ctrl;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_cond = 1'b1;
    logic          sclk_pos = 1'b0;
    logic          sclk_neg = 1'b0;
    logic          mosi_cond = 1'b0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          miso;
    logic          miso_en;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            we_cycles = 0;
    logic [AW-1:0] last_we_addr = '0;
    logic [DW-1:0] last_we_data = '0;

    spi_transaction_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_cond   (cs_cond),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .mosi_cond (mosi_cond),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .miso      (miso),
        .miso_en   (miso_en),
        .busy      (busy)
    );

    // clock / memory block
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
            we_cycles     <= we_cycles + 1;
            last_we_addr  <= mem_addr;
            last_we_data  <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK period: rising edge then falling edge, each half-period 4 clk.
    task automatic send_bit(input logic b, output logic m, output logic en_p);
        mosi_cond = b;
        sclk_pos  = 1'b1;
        @(negedge clk);
        sclk_pos  = 1'b0;
        en_p      = miso_en;
        tick(3);
        sclk_neg  = 1'b1;
        @(negedge clk);
        sclk_neg  = 1'b0;
        m         = miso;
        tick(3);
    endtask

    // Leaves CS low; nd data bits are clocked after the command.
    task automatic run_txn(input logic [AW-1:0] addr, input logic rw,
                           input logic [DW-1:0] wdata, input int nd);
        logic          m, e;
        logic [DW-1:0] exp_rd;
        exp_rd  = ref_mem[addr];
        cs_cond = 1'b0;
        tick(2);
        for (int i = AW - 1; i >= 0; i--) send_bit(addr[i], m, e);
        send_bit(rw, m, e);
        if (rw) begin
            check("miso_en_in_load", e, 1'b0);
            check("miso_bit7", m, exp_rd[DW-1]);
        end
        for (int j = 0; j < nd; j++) begin
            if (rw) begin
                send_bit(1'($urandom_range(0, 1)), m, e);
                check($sformatf("miso_en_bit%0d", j), e, (j < DW - 1) ? 1'b1 : 1'b0);
                if (j < DW - 1) check($sformatf("miso_bit%0d", DW - 2 - j), m, exp_rd[DW-2-j]);
            end else begin
                send_bit(wdata[DW-1-j], m, e);
            end
        end
    endtask

    task automatic end_txn();
        check("busy_before_cs_rise", busy, 1'b1);
        cs_cond = 1'b1;
        tick(1);
        check("busy_after_cs_rise", busy, 1'b0);
        tick(2);
    endtask

    task automatic full_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int we0;
        we0 = we_cycles;
        run_txn(addr, 1'b0, data, DW);
        check("we_single_pulse", we_cycles - we0, 1);
        check("we_addr", last_we_addr, addr);
        check("we_data", last_we_data, data);
        ref_mem[addr] = data;
    endtask

    initial begin
        int            we0;
        logic          m, e;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[7'h2A]     = 8'h3C;
        ref_mem[7'h2A] = 8'h3C;

        // reset values
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_miso_en", miso_en, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy_cs_high", busy, 1'b0);

        // write 0x15 = 0xA5
        full_write(7'h15, 8'hA5);
        end_txn();

        // read preloaded 0x2A = 0x3C
        run_txn(7'h2A, 1'b1, '0, DW);
        check("read_mem_we_quiet", mem_we, 1'b0);
        end_txn();

        // abort mid-write after 4 data bits
        we0 = we_cycles;
        run_txn(7'h33, 1'b0, 8'hF0, 4);
        cs_cond = 1'b1;
        tick(1);
        check("abort_idle_next_clk", busy, 1'b0);
        tick(4);
        check("abort_no_we", we_cycles - we0, 0);

        // reset asserted mid-read after 3 data bits
        run_txn(7'h2A, 1'b1, '0, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_miso_en", miso_en, 1'b0);
        check("midrst_miso", miso, 1'b0);
        check("midrst_mem_addr", mem_addr, '0);
        check("midrst_mem_we", mem_we, 1'b0);
        tick(2);
        cs_cond = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        run_txn(7'h2A, 1'b1, '0, DW);
        end_txn();

        // back-to-back write then read
        full_write(7'h01, 8'h77);
        end_txn();
        run_txn(7'h01, 1'b1, '0, DW);
        end_txn();

        // extra SCLK in DONE must not cause another write
        full_write(7'h40, 8'h5A);
        we0 = we_cycles;
        for (int k = 0; k < DW; k++) send_bit(1'($urandom_range(0, 1)), m, e);
        check("done_no_extra_we", we_cycles - we0, 0);
        check("done_miso_en", miso_en, 1'b0);
        check("done_mem_addr_held", mem_addr, 7'h40);
        end_txn();

        // randomized traffic over a small address window so reads hit earlier writes
        for (int t = 0; t < 10; t++) begin
            ra = 7'h60 + 7'($urandom_range(0, 3));
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                run_txn(ra, 1'b1, '0, DW);
            end else begin
                full_write(ra, rd);
            end
            end_txn();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
